// File: rtl/score_pkg.sv
// Shared types and constants for the score tracker: FSM state encoding,
// display-mode selectors and the streak bonus threshold.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    COMMIT = 2'd2,
    SHOW   = 2'd3
  } state_t;

  localparam logic [1:0] DISP_CUR  = 2'd0;
  localparam logic [1:0] DISP_PB   = 2'd1;
  localparam logic [1:0] DISP_HIGH = 2'd2;
  localparam logic [1:0] DISP_WINS = 2'd3;

  // Hits already in the streak before a hit starts earning the bonus.
  localparam int STREAK_THRESH = 3;

endpackage

// File: rtl/score_tracker_if.sv
// Game-event bus from the answer checker / round timer into the tracker.
// master drives the events, slave (the tracker) consumes them.
interface score_tracker_if #(
  parameter int NUM_PLAYERS = 4
) ();

  logic                           round_start;
  logic [$clog2(NUM_PLAYERS)-1:0] player_sel;
  logic                           hit;
  logic                           miss;
  logic                           game_timeout;

  modport master (
    output round_start, player_sel, hit, miss, game_timeout
  );

  modport slave (
    input round_start, player_sel, hit, miss, game_timeout
  );

endinterface

// File: rtl/score_bin2bcd.sv
// Combinational binary-to-BCD converter (double-dabble). Digit 0 (ones)
// lands in the LSBs of bcd.
module score_bin2bcd #(
  parameter int SCORE_W = 7,
  parameter int DIGITS  = 2
) (
  input  logic [SCORE_W-1:0]  bin,
  output logic [4*DIGITS-1:0] bcd
);

  logic [4*DIGITS+SCORE_W-1:0] sr;

  // Add-3 on every digit >= 5, then shift; one pass per binary bit.
  always_comb begin
    sr = '0;
    sr[SCORE_W-1:0] = bin;
    for (int i = 0; i < SCORE_W; i++) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (sr[SCORE_W+4*d +: 4] >= 4'd5)
          sr[SCORE_W+4*d +: 4] = sr[SCORE_W+4*d +: 4] + 4'd3;
      end
      sr = sr << 1;
    end
    bcd = sr[SCORE_W +: 4*DIGITS];
  end

endmodule

// File: rtl/score_tracker.sv
// Multi-player score keeper for the prime-prediction game. Counts hits for
// the active player, commits to personal bests / high score / wins on
// timeout, and drives a registered BCD display value.
// Optional build macro SCORE_STREAK_EN: consecutive-hit bonus plus streak_o.
module score_tracker
  import score_pkg::*;
#(
  parameter int NUM_PLAYERS = 4,
  parameter int SCORE_W     = 7,
  parameter int MAX_SCORE   = 99,
  parameter int DIGITS      = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  score_tracker_if.slave                 ev,
  input  logic [1:0]                     disp_mode,
`ifdef SCORE_STREAK_EN
  output logic [3:0]                     streak_o,
`endif
  output logic [SCORE_W-1:0]             current_score,
  output logic [SCORE_W-1:0]             high_score,
  output logic [$clog2(NUM_PLAYERS)-1:0] high_player,
  output logic                           new_record,
  output logic [1:0]                     state_o,
  output logic [4*DIGITS-1:0]            bcd_digits
);

  localparam int PW = $clog2(NUM_PLAYERS);
  localparam logic [SCORE_W-1:0] MAX_S = SCORE_W'(MAX_SCORE);

  state_t               state;
  logic [PW-1:0]        player;
  logic [SCORE_W-1:0]   pb   [NUM_PLAYERS];
  logic [SCORE_W-1:0]   wins [NUM_PLAYERS];
  logic [1:0]           inc;
  logic [SCORE_W-1:0]   disp_val;
  logic [4*DIGITS-1:0]  bcd_next;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [1:0] b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {{(SCORE_W-1){1'b0}}, b};
    if (sum > {1'b0, MAX_S}) return MAX_S;
    return sum[SCORE_W-1:0];
  endfunction

  function automatic logic [PW-1:0] clamp_player(input logic [PW-1:0] sel);
    if (int'(sel) > NUM_PLAYERS - 1) return PW'(NUM_PLAYERS - 1);
    return sel;
  endfunction

`ifdef SCORE_STREAK_EN
  logic [3:0] streak;
  assign inc      = (streak >= 4'(STREAK_THRESH)) ? 2'd2 : 2'd1;
  assign streak_o = streak;
`else
  assign inc = 2'd1;
`endif

  // Round FSM together with score, personal-best, high-score and win state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      player        <= '0;
      current_score <= '0;
      high_score    <= '0;
      high_player   <= '0;
      new_record    <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        pb[i]   <= '0;
        wins[i] <= '0;
      end
`ifdef SCORE_STREAK_EN
      streak <= '0;
`endif
    end else begin
      case (state)
        IDLE, SHOW: begin
          if (ev.round_start) begin
            state         <= PLAY;
            player        <= clamp_player(ev.player_sel);
            current_score <= '0;
            new_record    <= 1'b0;
`ifdef SCORE_STREAK_EN
            streak        <= '0;
`endif
          end
        end
        PLAY: begin
          // miss dominates a simultaneous hit; a hit with timeout still counts
          if (ev.hit && !ev.miss) begin
            current_score <= sat_add(current_score, inc);
`ifdef SCORE_STREAK_EN
            if (streak != 4'hF) streak <= streak + 4'd1;
`endif
          end
`ifdef SCORE_STREAK_EN
          else if (ev.miss) begin
            streak <= '0;
          end
`endif
          if (ev.game_timeout) state <= COMMIT;
        end
        COMMIT: begin
          if (current_score > pb[player]) pb[player] <= current_score;
          // strict compare: a tie leaves the existing holder in place
          if (current_score > high_score) begin
            high_score   <= current_score;
            high_player  <= player;
            new_record   <= 1'b1;
            wins[player] <= sat_add(wins[player], 2'd1);
          end
          state <= SHOW;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign state_o = state;

  // Select the value shown on the display.
  always_comb begin
    disp_val = current_score;
    case (disp_mode)
      DISP_PB:   disp_val = pb[player];
      DISP_HIGH: disp_val = high_score;
      DISP_WINS: disp_val = wins[player];
      default:   disp_val = current_score;
    endcase
  end

  score_bin2bcd #(
    .SCORE_W (SCORE_W),
    .DIGITS  (DIGITS)
  ) u_bin2bcd (
    .bin (disp_val),
    .bcd (bcd_next)
  );

  // Register the converted digits so the display bus is glitch-free.
  always_ff @(posedge clk) begin
    if (!reset) bcd_digits <= '0;
    else        bcd_digits <= bcd_next;
  end

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker (default build: no streak bonus).
module tb_score_tracker;

  logic       clk;
  logic       reset;
  logic [1:0] disp_mode;
  logic [6:0] current_score;
  logic [6:0] high_score;
  logic [1:0] high_player;
  logic       new_record;
  logic [1:0] state_o;
  logic [7:0] bcd_digits;
`ifdef SCORE_STREAK_EN
  logic [3:0] streak_o;
`endif

  int checks   = 0;
  int failures = 0;

  score_tracker_if #(.NUM_PLAYERS(4)) ev ();

  score_tracker #(
    .NUM_PLAYERS (4),
    .SCORE_W     (7),
    .MAX_SCORE   (99),
    .DIGITS      (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ev            (ev),
    .disp_mode     (disp_mode),
`ifdef SCORE_STREAK_EN
    .streak_o      (streak_o),
`endif
    .current_score (current_score),
    .high_score    (high_score),
    .high_player   (high_player),
    .new_record    (new_record),
    .state_o       (state_o),
    .bcd_digits    (bcd_digits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic start_round(input logic [1:0] p);
    @(negedge clk);
    ev.player_sel  = p;
    ev.round_start = 1'b1;
    @(negedge clk);
    ev.round_start = 1'b0;
  endtask

  task automatic hits(input int n);
    @(negedge clk);
    ev.hit = 1'b1;
    repeat (n - 1) @(negedge clk);
    @(negedge clk);
    ev.hit = 1'b0;
  endtask

  // Pulse timeout, then step through COMMIT into SHOW.
  task automatic timeout_round();
    @(negedge clk);
    ev.game_timeout = 1'b1;
    @(negedge clk);
    ev.game_timeout = 1'b0;
    @(negedge clk);
  endtask

  task automatic show(input logic [1:0] m);
    disp_mode = m;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset           = 1'b0;
    disp_mode       = 2'd0;
    ev.round_start  = 1'b0;
    ev.player_sel   = 2'd0;
    ev.hit          = 1'b0;
    ev.miss         = 1'b0;
    ev.game_timeout = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_state", state_o, 0);
    check("rst_score", current_score, 0);
    check("rst_high", high_score, 0);
    check("rst_hplayer", high_player, 0);
    check("rst_newrec", new_record, 0);
    check("rst_bcd", bcd_digits, 0);
    reset = 1'b1;

    // player 1: 12 hits, first record
    start_round(2'd1);
    check("p1_play", state_o, 1);
    hits(12);
    check("p1_score", current_score, 12);
    @(negedge clk);
    ev.game_timeout = 1'b1;
    @(negedge clk);
    ev.game_timeout = 1'b0;
    check("p1_commit", state_o, 2);
    @(negedge clk);
    check("p1_show", state_o, 3);
    check("p1_high", high_score, 12);
    check("p1_hplayer", high_player, 1);
    check("p1_newrec", new_record, 1);
    show(2'd0);
    check("p1_bcd_cur", bcd_digits, 8'h12);
    show(2'd1);
    check("p1_bcd_pb", bcd_digits, 8'h12);
    show(2'd3);
    check("p1_bcd_wins", bcd_digits, 8'h01);
    show(2'd2);
    check("p1_bcd_high", bcd_digits, 8'h12);

    // player 2: tie at 12 keeps player 1 as holder
    start_round(2'd2);
    check("p2_clear_score", current_score, 0);
    check("p2_clear_newrec", new_record, 0);
    hits(12);
    timeout_round();
    check("p2_show", state_o, 3);
    check("p2_high", high_score, 12);
    check("p2_hplayer", high_player, 1);
    check("p2_newrec", new_record, 0);
    show(2'd1);
    check("p2_bcd_pb", bcd_digits, 8'h12);
    show(2'd3);
    check("p2_bcd_wins", bcd_digits, 8'h00);

    // player 0: 120 hits saturate at 99
    start_round(2'd0);
    hits(120);
    check("sat_score", current_score, 99);
    show(2'd0);
    check("sat_bcd", bcd_digits, 8'h99);
    timeout_round();
    check("sat_high", high_score, 99);
    check("sat_hplayer", high_player, 0);
    check("sat_newrec", new_record, 1);
    show(2'd3);
    check("sat_bcd_wins", bcd_digits, 8'h01);

    // player 3: hit, hit+miss (ignored), hit+timeout (counted)
    start_round(2'd3);
    hits(1);
    check("hm_first", current_score, 1);
    @(negedge clk);
    ev.hit  = 1'b1;
    ev.miss = 1'b1;
    @(negedge clk);
    ev.miss = 1'b0;
    check("hm_both", current_score, 1);
    ev.game_timeout = 1'b1;
    @(negedge clk);
    ev.hit          = 1'b0;
    ev.game_timeout = 1'b0;
    check("hm_timeout_hit", current_score, 2);
    @(negedge clk);
    check("hm_show", state_o, 3);
    check("hm_high_kept", high_score, 99);
    hits(3);
    check("show_ignores_hit", current_score, 2);
    show(2'd1);
    check("hm_bcd_pb", bcd_digits, 8'h02);

    // reset mid-round with score 7
    start_round(2'd1);
    hits(7);
    check("mid_score", current_score, 7);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("mid_state", state_o, 0);
    check("mid_score_clr", current_score, 0);
    check("mid_high_clr", high_score, 0);
    check("mid_hplayer_clr", high_player, 0);
    check("mid_newrec_clr", new_record, 0);
    check("mid_bcd_clr", bcd_digits, 0);
    show(2'd1);
    check("mid_pb_zero", bcd_digits, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_tracker.md
Name: score_tracker

Overview:
- Parametrised multi-player score keeper for the prime-prediction game.
- Counts correct predictions for the active player during a round. On timeout it commits the score to per-player personal bests, the global high score and per-player win counters.
- Drives a BCD digit bus to the seven-segment driver, selected by display mode.
- Sits between the answer checker/round timer and the SSD mux.

Parameters:
- NUM_PLAYERS, 4, number of players tracked (>=2).
- SCORE_W, 7, binary width of scores and win counts.
- MAX_SCORE, 99, saturation value for score and win counts (< 2**SCORE_W).
- DIGITS, 2, BCD digits driven to the display (10**DIGITS > MAX_SCORE).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- round_start  in  1  pulse: begin a round for player_sel
- player_sel  in  $clog2(NUM_PLAYERS)  player index, sampled on round_start
- hit  in  1  pulse: correct prediction
- miss  in  1  pulse: wrong prediction
- game_timeout  in  1  pulse: round time expired
- disp_mode  in  2  0=current score, 1=personal best of active player, 2=high score, 3=wins of active player
- current_score  out  SCORE_W  live score of the round
- high_score  out  SCORE_W  global best
- high_player  out  $clog2(NUM_PLAYERS)  holder of high_score
- new_record  out  1  set when the last commit beat high_score
- state_o  out  2  FSM state (debug/LED)
- bcd_digits  out  4*DIGITS  display value; digit 0 (ones) in the LSBs

Behaviour:
- Reset (reset==0 at posedge clk):
  - state=IDLE.
  - All scores, personal bests, wins, high_score, high_player, new_record and bcd_digits are 0.
  - Reset applied mid-round discards the round with no commit.
- FSM states: IDLE(0), PLAY(1), COMMIT(2), SHOW(3).
  - IDLE: on round_start -> PLAY, latch player_sel, clear current_score and new_record.
  - PLAY:
    - hit increments current_score, saturating at MAX_SCORE.
    - miss leaves the score unchanged.
    - hit and miss asserted together: miss wins (no increment).
    - game_timeout -> COMMIT. If game_timeout and hit coincide, the hit is counted first.
    - round_start is ignored while in PLAY.
  - COMMIT (exactly one cycle):
    - If current_score > pb[p], then pb[p] = current_score.
    - If current_score > high_score (strict), then high_score = current_score, high_player = p, new_record = 1, and wins[p] increments (saturating at MAX_SCORE).
    - A tie does not displace the holder. Then -> SHOW.
  - SHOW:
    - current_score is held; hit, miss and game_timeout are ignored.
    - round_start -> PLAY with the same latch/clear actions as IDLE.
- player_sel values >= NUM_PLAYERS are clamped to NUM_PLAYERS-1.
- Display:
  - bcd_digits is a register updated every cycle from the disp_mode-selected value (1-cycle latency).
  - Binary-to-BCD conversion is combinational (double-dabble).
  - In PLAY, disp_mode 1-3 remain selectable.
- All outputs are registered.

Optional Feature:
- SCORE_STREAK_EN defined:
  - A streak counter counts consecutive hits. miss or round_start clears it.
  - From the 4th consecutive hit onward, each hit adds 2 (still saturating at MAX_SCORE).
  - Adds output streak_o [3:0], saturating at 15.
- Undefined: every hit adds 1, and streak_o is absent.

Decomposition:
- Package score_pkg:
  - state enum (IDLE, PLAY, COMMIT, SHOW)
  - disp_mode constants (DISP_CUR, DISP_PB, DISP_HIGH, DISP_WINS)
  - STREAK_THRESH=3
- Sub-module score_bin2bcd (parameters SCORE_W, DIGITS): combinational double-dabble, instantiated once on the muxed display value.

Test Plan:
- Reset, then round_start with player_sel=1, 12 hits, game_timeout, disp_mode=0 -> current_score=12, bcd_digits=0x12, pb[1]=12, high_score=12, high_player=1, new_record=1, wins[1]=1.
- Player 2 round: 12 hits, timeout -> tie, so high_player stays 1, new_record=0, disp_mode=1 shows 0x12.
- 120 hits with MAX_SCORE=99 -> score saturates at 99, bcd_digits=0x99, no wrap.
- hit and miss in the same cycle, then hit with game_timeout in the same cycle -> first ignored, second counted, FSM reaches SHOW.
- reset low mid-PLAY with score 7 -> all outputs 0, state IDLE, pb unchanged from 0.
- SCORE_STREAK_EN: 5 hits -> score 1+1+1+2+2=7, streak_o=5; then miss, then hit -> score 8, streak_o=1.
